id_decode_stage: RTL
====================

// Module: id_decode_stage
// PURPOSE
//  Instruction-decode pipeline stage; drives the execute stage's ALU.
//  Takes a fetched 16-bit instruction and its PC, and produces a registered decode bundle:
//  opcode, 7-bit alu_control, register addresses, extended immediate, writeback/memory/branch
//  controls and flag-write enables.
//  Detects load-use hazards and inserts one bubble when one occurs; honours downstream stall and flush.
// PARAMETERS
//  DATA_W  16  instruction/PC/immediate width
//  REG_AW  3   register address width (8 GPRs)
// PORTS
//  clk          in   1       clock, rising edge
//  rst          in   1       synchronous, active-high reset
//  in_valid     in   1       instr/in_pc valid from fetch
//  instr        in   16      instruction word
//  in_pc        in   16      PC of instr
//  stall_in     in   1       execute stage cannot accept; hold outputs
//  flush        in   1       branch/jump redirect; squash
//  in_ready     out  1       combinational; 1 = this cycle's instr is consumed
//  out_valid    out  1       decode bundle valid
//  opcode       out  4       instr[15:12]
//  alu_control  out  7       to ALU
//  rs1, rs2     out  3 each  source register addresses (op1, op2)
//  rd           out  3       destination register address
//  imm          out  16      extended immediate
//  pc_out       out  16      PC (ALU op3)
//  wb           out  1       register writeback enable
//  mem_rd       out  1       load
//  mem_wr       out  1       store
//  is_branch    out  1       BEQ/BLT/BLE
//  is_jump      out  1       JAL/JRI
//  carry_we     out  1       instruction may update carry
//  zero_we      out  1       instruction may update zero
//  illegal      out  1       one-cycle pulse; unsupported opcode dropped
// BEHAVIOUR
//  Fields: op=[15:12], RA=[11:9], RB=[8:6], RC=[5:3], C=[2], CZ=[1:0], imm6=[5:0], imm9=[8:0].
//  alu_control:
//   - op 0000/0010: {op,instr[2:0]}
//   - all other legal ops: {op,3'b000}
//  Per-opcode decode (rs1 / rs2 / rd / imm / flags):
//   - 0000 ADD grp: RA / RB / RC; wb=1; carry_we=1, zero_we=1
//   - 0010 NAND grp: RA / RB / RC; wb=1; zero_we=1
//   - 0001 ADDI: RA / - / RB; imm=sext(imm6); wb=1; carry_we=1, zero_we=1
//   - 0011 LLI: rd=RA; imm=zext(imm9); wb=1
//   - 0100 LW: RB / - / RA; imm=sext(imm6); wb=1, mem_rd=1
//   - 0101 SW: RB / RA; imm=sext(imm6); mem_wr=1
//   - 1000/1001/1010 BEQ/BLT/BLE: RA / RB; imm=sext(imm6); is_branch=1
//   - 1011 JAL: rd=RA; imm=sext(imm9); wb=1, is_jump=1
//   - 1101 JRI: rs1=RA; imm=sext(imm9); is_jump=1
//   - Unused fields drive 0.
//  Illegal opcodes: 0110, 0111, 1100, 1110, 1111.
//   - Consumed (in_ready=1); loads a bubble; illegal=1 for one cycle.
//  Load-use hazard, combinational:
//   - hz = out_valid & mem_rd & in_valid & (rd==src1 of instr, or rd==src2 of instr, where used).
//  Register update priority, per cycle:
//   1. rst: all outputs 0, including out_valid and illegal.
//   2. flush: out_valid=0, all controls 0; in_ready=0 (fetched instr is squashed, not decoded).
//   3. stall_in: all outputs hold; in_ready=0; illegal=0.
//   4. hz: bubble (out_valid=0, wb/mem/branch/we=0); in_ready=0; instr is re-presented next cycle.
//   5. in_valid: load decode; out_valid=1 (0 if illegal); in_ready=1.
//   6. otherwise: bubble.
//  Latency: 1 clk from consume to out_valid.
//  Bubble contents: a bubble clears every control output; data fields are don't-care.
//  Simultaneous events:
//   - flush wins over stall_in and hz.
//   - stall_in with hz: hold (no bubble inserted).
//   - rst mid-stall: clears all outputs.
// TESTING
//  - 0x0298 ADD R3=R1+R2 -> next clk: alu_control=7'b0000000, rs1=1, rs2=2, rd=3, wb=1,
//    carry_we=1, zero_we=1. 0x029A -> alu_control=7'b0000010.
//  - 0x12BF ADDI -> rd=2, imm=16'hFFFF, alu_control=7'b0001000.
//    0x33FF LLI -> rd=1, imm=16'h01FF.
//    0xBFFE JAL, in_pc=16'h0040 -> rd=7, imm=16'hFFFE, pc_out=16'h0040, is_jump=1, wb=1.
//  - 0x4842 LW R4 then 0x08A8 ADD R5=R4+R2 -> in_ready=0 one cycle, one bubble,
//    then ADD issues with rs1=4, rs2=2, rd=5.
//  - stall_in=1 for 3 clks while ADD bundle valid -> outputs stable, in_ready=0.
//    flush during the stall -> out_valid=0 next clk.
//  - 0x7000 -> in_ready=1, illegal=1 for one clk, out_valid=0.
//    rst asserted mid-stream -> all outputs 0 next clk.

Source files
------------

// File: rtl/id_decode_stage.sv
// Instruction-decode pipeline stage: decodes a 16-bit instruction into a registered
// bundle for the execute stage, with load-use bubble insertion, stall hold and flush.
module id_decode_stage #(
  parameter int DATA_W = 16,
  parameter int REG_AW = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] instr,
  input  logic [DATA_W-1:0] in_pc,
  input  logic              stall_in,
  input  logic              flush,
  output logic              in_ready,
  output logic              out_valid,
  output logic [3:0]        opcode,
  output logic [6:0]        alu_control,
  output logic [REG_AW-1:0] rs1,
  output logic [REG_AW-1:0] rs2,
  output logic [REG_AW-1:0] rd,
  output logic [DATA_W-1:0] imm,
  output logic [DATA_W-1:0] pc_out,
  output logic              wb,
  output logic              mem_rd,
  output logic              mem_wr,
  output logic              is_branch,
  output logic              is_jump,
  output logic              carry_we,
  output logic              zero_we,
  output logic              illegal
);

  logic [3:0]        op;
  logic [REG_AW-1:0] f_ra, f_rb, f_rc;
  logic [DATA_W-1:0] sext6, sext9, zext9;

  assign op    = instr[15:12];
  assign f_ra  = instr[11:9];
  assign f_rb  = instr[8:6];
  assign f_rc  = instr[5:3];
  assign sext6 = {{(DATA_W-6){instr[5]}}, instr[5:0]};
  assign sext9 = {{(DATA_W-9){instr[8]}}, instr[8:0]};
  assign zext9 = {{(DATA_W-9){1'b0}}, instr[8:0]};

  logic [6:0]        d_alu;
  logic [REG_AW-1:0] d_rs1, d_rs2, d_rd;
  logic [DATA_W-1:0] d_imm;
  logic              d_use1, d_use2;
  logic              d_wb, d_mem_rd, d_mem_wr, d_branch, d_jump, d_cwe, d_zwe, d_ill;

  always_comb begin
    d_alu    = {op, 3'b000};
    d_rs1    = '0;
    d_rs2    = '0;
    d_rd     = '0;
    d_imm    = '0;
    d_use1   = 1'b0;
    d_use2   = 1'b0;
    d_wb     = 1'b0;
    d_mem_rd = 1'b0;
    d_mem_wr = 1'b0;
    d_branch = 1'b0;
    d_jump   = 1'b0;
    d_cwe    = 1'b0;
    d_zwe    = 1'b0;
    d_ill    = 1'b0;
    case (op)
      4'b0000: begin
        d_alu = {op, instr[2:0]};
        d_rs1 = f_ra; d_rs2 = f_rb; d_rd = f_rc;
        d_use1 = 1'b1; d_use2 = 1'b1;
        d_wb = 1'b1; d_cwe = 1'b1; d_zwe = 1'b1;
      end
      4'b0010: begin
        d_alu = {op, instr[2:0]};
        d_rs1 = f_ra; d_rs2 = f_rb; d_rd = f_rc;
        d_use1 = 1'b1; d_use2 = 1'b1;
        d_wb = 1'b1; d_zwe = 1'b1;
      end
      4'b0001: begin
        d_rs1 = f_ra; d_rd = f_rb; d_imm = sext6;
        d_use1 = 1'b1;
        d_wb = 1'b1; d_cwe = 1'b1; d_zwe = 1'b1;
      end
      4'b0011: begin
        d_rd = f_ra; d_imm = zext9;
        d_wb = 1'b1;
      end
      4'b0100: begin
        d_rs1 = f_rb; d_rd = f_ra; d_imm = sext6;
        d_use1 = 1'b1;
        d_wb = 1'b1; d_mem_rd = 1'b1;
      end
      4'b0101: begin
        d_rs1 = f_rb; d_rs2 = f_ra; d_imm = sext6;
        d_use1 = 1'b1; d_use2 = 1'b1;
        d_mem_wr = 1'b1;
      end
      4'b1000, 4'b1001, 4'b1010: begin
        d_rs1 = f_ra; d_rs2 = f_rb; d_imm = sext6;
        d_use1 = 1'b1; d_use2 = 1'b1;
        d_branch = 1'b1;
      end
      4'b1011: begin
        d_rd = f_ra; d_imm = sext9;
        d_wb = 1'b1; d_jump = 1'b1;
      end
      4'b1101: begin
        d_rs1 = f_ra; d_imm = sext9;
        d_use1 = 1'b1;
        d_jump = 1'b1;
      end
      default: begin
        d_alu = '0;
        d_ill = 1'b1;
      end
    endcase
  end

  // Only a load still sitting in the output register can create a load-use hazard.
  logic hz;
  assign hz = out_valid & mem_rd & in_valid &
              ((d_use1 & (rd == d_rs1)) | (d_use2 & (rd == d_rs2)));

  assign in_ready = in_valid & ~rst & ~flush & ~stall_in & ~hz;

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid   <= 1'b0;
      opcode      <= '0;
      alu_control <= '0;
      rs1         <= '0;
      rs2         <= '0;
      rd          <= '0;
      imm         <= '0;
      pc_out      <= '0;
      wb          <= 1'b0;
      mem_rd      <= 1'b0;
      mem_wr      <= 1'b0;
      is_branch   <= 1'b0;
      is_jump     <= 1'b0;
      carry_we    <= 1'b0;
      zero_we     <= 1'b0;
      illegal     <= 1'b0;
    end else if (stall_in && !flush) begin
      illegal <= 1'b0;
    end else if (flush || hz || !in_valid) begin
      // Bubble: data fields keep their last value, controls are cleared.
      out_valid <= 1'b0;
      wb        <= 1'b0;
      mem_rd    <= 1'b0;
      mem_wr    <= 1'b0;
      is_branch <= 1'b0;
      is_jump   <= 1'b0;
      carry_we  <= 1'b0;
      zero_we   <= 1'b0;
      illegal   <= 1'b0;
    end else begin
      out_valid   <= ~d_ill;
      opcode      <= op;
      alu_control <= d_alu;
      rs1         <= d_rs1;
      rs2         <= d_rs2;
      rd          <= d_rd;
      imm         <= d_imm;
      pc_out      <= in_pc;
      wb          <= d_wb;
      mem_rd      <= d_mem_rd;
      mem_wr      <= d_mem_wr;
      is_branch   <= d_branch;
      is_jump     <= d_jump;
      carry_we    <= d_cwe;
      zero_we     <= d_zwe;
      illegal     <= d_ill;
    end
  end

endmodule
